// File: rtl/uart_cmd_framer_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared constants for the UART command framer: default sync marker, FSM
// state encodings, error-counter width and frame overhead sizes.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

   // Frame start marker used when the instantiating level does not override it.
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // FSM state encodings.
   localparam logic [2:0] S_HUNT    = 3'd0;
   localparam logic [2:0] S_OPCODE  = 3'd1;
   localparam logic [2:0] S_LEN     = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
   localparam logic [2:0] S_CHK     = 3'd4;

   // Width of every saturating debug error counter.
   localparam int ERR_CNT_W = 16;

   // Frame overhead: SYNC + OPCODE + LEN in front, one CHK byte at the end.
   localparam int HDR_BYTES = 3;
   localparam int CHK_BYTES = 1;

   // Total bytes on the wire for a frame carrying len payload bytes.
   function automatic int frame_bytes(input int len);
      return HDR_BYTES + len + CHK_BYTES;
   endfunction

endpackage

// File: rtl/uart_cmd_framer_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_framer_if
// Bundles the byte stream coming from the UART receiver and the command
// valid/ready output channel of the framer.
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   cmd_valid/ready  : command register handshake
//   cmd_opcode       : frame opcode
//   cmd_len          : payload byte count
//   cmd_payload      : byte i at [8i+7:8i], unused bytes zero
// Modports:
//   master : the framer (consumes rx, produces commands)
//   slave  : the surrounding logic (produces rx, consumes commands)
// -----------------------------------------------------------------------------
interface uart_cmd_framer_if #(
   parameter int MAX_LEN = 8
);
   logic [7:0]           rx_data;
   logic                 rx_valid;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [7:0]           cmd_opcode;
   logic [4:0]           cmd_len;
   logic [8*MAX_LEN-1:0] cmd_payload;

   modport master (
      input  rx_data, rx_valid, cmd_ready,
      output cmd_valid, cmd_opcode, cmd_len, cmd_payload
   );

   modport slave (
      output rx_data, rx_valid, cmd_ready,
      input  cmd_valid, cmd_opcode, cmd_len, cmd_payload
   );
endinterface

// File: rtl/uart_cmd_framer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter
   import uart_cmd_pkg::*;
#(
   parameter int WIDTH = ERR_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // NOTE: registers are written with non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_framer.sv
// -----------------------------------------------------------------------------
// uart_cmd_framer
// Hunts for SYNC in the UART byte stream, assembles length-prefixed,
// XOR-checked frames in a shadow register set and hands each good frame to
// the host through a one-deep valid/ready command register.
//   clk          : clock, all logic on posedge
//   rst          : synchronous active-high reset
//   bus          : rx byte stream in, command channel out (master modport)
//   err_chk_cnt  : frames with a checksum mismatch
//   err_len_cnt  : frames whose LEN exceeds MAX_LEN
//   err_tmo_cnt  : frames abandoned by the inter-byte timeout
//   err_drop_cnt : good frames lost because the command register was full
//   busy         : high while a frame is being assembled
// -----------------------------------------------------------------------------
module uart_cmd_framer
   import uart_cmd_pkg::*;
#(
   parameter int         MAX_LEN      = 8,
   parameter int         TIMEOUT_CLKS = 125_000,
   parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_cmd_framer_if.master    bus,
   output logic [ERR_CNT_W-1:0] err_chk_cnt,
   output logic [ERR_CNT_W-1:0] err_len_cnt,
   output logic [ERR_CNT_W-1:0] err_tmo_cnt,
   output logic [ERR_CNT_W-1:0] err_drop_cnt,
   output logic                 busy
);

   localparam int                PL_W      = 8 * MAX_LEN;
   localparam int                TMO_W     = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

   logic [2:0]       state;
   logic [TMO_W-1:0] tmo_cnt;

   // Assembly shadow.
   logic [7:0]       opcode_sh;
   logic [4:0]       len_sh;
   logic [PL_W-1:0]  payload_sh;
   logic [4:0]       idx;
   logic [7:0]       xor_acc;

   // Command register.
   logic             cmd_valid_q;
   logic [7:0]       cmd_opcode_q;
   logic [4:0]       cmd_len_q;
   logic [PL_W-1:0]  cmd_payload_q;

   // Per-cycle decisions.
   logic tmo_hit;
   logic len_err;
   logic last_byte;
   logic load;
   logic err_chk;
   logic err_len;
   logic err_drop;

   assign len_err   = bus.rx_data > MAX_LEN_B;
   assign last_byte = (idx + 5'd1) == len_sh;

   // NOTE: every signal assigned here gets a default first, so no path
   // through the case leaves it unassigned and infers a latch.
   always_comb begin
      tmo_hit  = 1'b0;
      load     = 1'b0;
      err_chk  = 1'b0;
      err_len  = 1'b0;
      err_drop = 1'b0;

      // A byte arriving on the terminal count wins over the timeout.
      if ((state != S_HUNT) && !bus.rx_valid && (tmo_cnt == TMO_LAST)) begin
         tmo_hit = 1'b1;
      end

      if (bus.rx_valid) begin
         case (state)
            S_LEN: err_len = len_err;
            S_CHK: begin
               if (bus.rx_data != xor_acc) begin
                  err_chk = 1'b1;
               end else if (!cmd_valid_q || bus.cmd_ready) begin
                  load = 1'b1;
               end else begin
                  err_drop = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the shadow set has no reset: OPCODE and LEN always rewrite it
   // before a frame can reach CHK, and outputs only change on a load.
   always_ff @(posedge clk) begin
      if (bus.rx_valid) begin
         case (state)
            S_OPCODE: begin
               opcode_sh <= bus.rx_data;
               xor_acc   <= bus.rx_data;
            end
            S_LEN: begin
               len_sh     <= bus.rx_data[4:0];
               xor_acc    <= xor_acc ^ bus.rx_data;
               idx        <= '0;
               payload_sh <= '0;
            end
            S_PAYLOAD: begin
               payload_sh[8*idx +: 8] <= bus.rx_data;
               xor_acc                <= xor_acc ^ bus.rx_data;
               idx                    <= idx + 5'd1;
            end
            default: ;
         endcase
      end
   end

   // FSM, inter-byte timer and command register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_HUNT;
         tmo_cnt       <= '0;
         cmd_valid_q   <= 1'b0;
         cmd_opcode_q  <= '0;
         cmd_len_q     <= '0;
         cmd_payload_q <= '0;
      end else begin
         // Timer idles at zero while hunting; any byte restarts it.
         if (bus.rx_valid || (state == S_HUNT) || tmo_hit) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end

         if (tmo_hit) begin
            state <= S_HUNT;
         end else if (bus.rx_valid) begin
            case (state)
               S_HUNT: begin
                  if (bus.rx_data == SYNC_BYTE) state <= S_OPCODE;
               end
               S_OPCODE: state <= S_LEN;
               S_LEN: begin
                  if (len_err)                   state <= S_HUNT;
                  else if (bus.rx_data == 8'd0)  state <= S_CHK;
                  else                           state <= S_PAYLOAD;
               end
               S_PAYLOAD: begin
                  if (last_byte) state <= S_CHK;
               end
               default: state <= S_HUNT;   // S_CHK and unused encodings
            endcase
         end

         // A load in the same cycle as a handshake keeps valid high.
         if (load) begin
            cmd_valid_q   <= 1'b1;
            cmd_opcode_q  <= opcode_sh;
            cmd_len_q     <= len_sh;
            cmd_payload_q <= payload_sh;
         end else if (cmd_valid_q && bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
         end
      end
   end

   assign bus.cmd_valid   = cmd_valid_q;
   assign bus.cmd_opcode  = cmd_opcode_q;
   assign bus.cmd_len     = cmd_len_q;
   assign bus.cmd_payload = cmd_payload_q;
   assign busy            = state != S_HUNT;

   sat_counter #(.WIDTH(ERR_CNT_W)) u_err_chk (
      .clk(clk), .rst(rst), .inc(err_chk), .count(err_chk_cnt)
   );

   sat_counter #(.WIDTH(ERR_CNT_W)) u_err_len (
      .clk(clk), .rst(rst), .inc(err_len), .count(err_len_cnt)
   );

   sat_counter #(.WIDTH(ERR_CNT_W)) u_err_tmo (
      .clk(clk), .rst(rst), .inc(tmo_hit), .count(err_tmo_cnt)
   );

   sat_counter #(.WIDTH(ERR_CNT_W)) u_err_drop (
      .clk(clk), .rst(rst), .inc(err_drop), .count(err_drop_cnt)
   );

endmodule
